memory_responder: RTL and testbench

Responder side of the processor's single-port RAM bus: answers the execution unit's address/read-enable/write-enable transactions on the shared bidirectional data net.
Owns the memory array and a boot sequencer (clear, then byte-stream program load) that holds the processor in reset until the program image is resident.
Sits at top level between the execution unit's ram_* ports and the test/boot loader.

---
 rtl/memory_responder.sv | 148 ++++++++++++++
 tb/tb_memory_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// Purpose : RAM-bus responder for the execution unit; owns the memory array and
//           a boot sequencer (CLEAR -> LOAD -> RUN) that holds the CPU in reset
//           until the program image is loaded.
// Latency : reads are combinational from ram_address (initiator samples on the
//           next posedge); writes and boot-word stores land on the posedge.
// Backpressure: load_ready is high only in LOAD; the bus is only served in RUN.
// Ports   : clk/reset (async, active-high); ram_address/ram_data/ram_read_en/
//           ram_write_en = execution-unit bus; load_valid/load_ready/load_addr/
//           load_data/load_last = boot-word stream; cpu_hold = CPU reset hold;
//           bus_error = sticky protocol-violation flag.
module memory_responder #(
   parameter int ADDR_BITS      = 8,
   parameter int DATA_BITS      = 8,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [ADDR_BITS-1:0] ram_address,
   inout  wire  [DATA_BITS-1:0] ram_data,
   input  logic                 ram_read_en,
   input  logic                 ram_write_en,
   input  logic                 load_valid,
   output logic                 load_ready,
   input  logic [ADDR_BITS-1:0] load_addr,
   input  logic [DATA_BITS-1:0] load_data,
   input  logic                 load_last,
   output logic                 cpu_hold,
   output logic                 bus_error
);

   localparam int DEPTH = 1 << ADDR_BITS;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_LOAD  = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_LOAD;

   state_t                state_q, state_d;
   logic [ADDR_BITS-1:0]  clr_addr_q, clr_addr_d;
   logic                  load_ready_q, load_ready_d;
   logic                  cpu_hold_q, cpu_hold_d;
   logic                  bus_error_q, bus_error_d;

   logic [DATA_BITS-1:0]  mem [DEPTH];

   // Single write port shared by the clear sweep, boot loads and bus writes;
   // the state decides which source owns it.
   logic                  mem_we;
   logic [ADDR_BITS-1:0]  mem_waddr;
   logic [DATA_BITS-1:0]  mem_wdata;
   logic                  drive_en;

   always_comb begin
      state_d      = state_q;
      clr_addr_d   = clr_addr_q;
      load_ready_d = load_ready_q;
      cpu_hold_d   = cpu_hold_q;
      bus_error_d  = bus_error_q;
      mem_we       = 1'b0;
      mem_waddr    = ram_address;
      mem_wdata    = ram_data;

      case (state_q)
         ST_CLEAR: begin
            mem_we     = 1'b1;
            mem_waddr  = clr_addr_q;
            mem_wdata  = '0;
            clr_addr_d = clr_addr_q + ADDR_BITS'(1);
            if (clr_addr_q == '1) begin
               state_d      = ST_LOAD;
               load_ready_d = 1'b1;
            end
            if (ram_read_en || ram_write_en) begin
               bus_error_d = 1'b1;
            end
         end

         ST_LOAD: begin
            load_ready_d = 1'b1;
            if (load_valid && load_ready_q) begin
               mem_we    = 1'b1;
               mem_waddr = load_addr;
               mem_wdata = load_data;
               if (load_last) begin
                  state_d      = ST_RUN;
                  load_ready_d = 1'b0;
                  cpu_hold_d   = 1'b0;
               end
            end
            if (ram_read_en || ram_write_en) begin
               bus_error_d = 1'b1;
            end
         end

         ST_RUN: begin
            load_ready_d = 1'b0;
            cpu_hold_d   = 1'b0;
            // A combined read+write still performs the write; the drive
            // enable below keeps the responder off the net.
            if (ram_write_en) begin
               mem_we = 1'b1;
            end
            if (ram_read_en && ram_write_en) begin
               bus_error_d = 1'b1;
            end
         end

         default: begin
            state_d = RESET_STATE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= RESET_STATE;
         clr_addr_q   <= '0;
         load_ready_q <= 1'b0;
         cpu_hold_q   <= 1'b1;
         bus_error_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_addr_q   <= clr_addr_d;
         load_ready_q <= load_ready_d;
         cpu_hold_q   <= cpu_hold_d;
         bus_error_q  <= bus_error_d;
      end
   end

   // Array has no reset so contents survive reset; a reset edge coinciding
   // with a clock edge must not let an in-flight write land.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   assign drive_en   = (state_q == ST_RUN) && ram_read_en && !ram_write_en;
   assign ram_data   = drive_en ? mem[ram_address] : {DATA_BITS{1'bz}};

   assign load_ready = load_ready_q;
   assign cpu_hold   = cpu_hold_q;
   assign bus_error  = bus_error_q;

endmodule

// File: tb/tb_memory_responder.sv
module tb_memory_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_a, reset_b;
   logic [7:0] ram_address;
   logic       ram_read_en, ram_write_en;
   logic       load_valid, load_last;
   logic [7:0] load_addr, load_data;
   logic       tb_drv;
   logic [7:0] tb_dat;

   wire  [7:0] ram_data_a, ram_data_b;
   logic       load_ready_a, cpu_hold_a, bus_error_a;
   logic       load_ready_b, cpu_hold_b, bus_error_b;

   // Bench-side write driver; a released net floats up to 8'hFF.
   assign ram_data_a = tb_drv ? tb_dat : 8'bz;
   assign ram_data_b = tb_drv ? tb_dat : 8'bz;
   pullup (ram_data_a);
   pullup (ram_data_b);

   memory_responder #(.ADDR_BITS(8), .DATA_BITS(8), .CLEAR_ON_RESET(1'b1)) dut_a (
      .clk(clk), .reset(reset_a),
      .ram_address(ram_address), .ram_data(ram_data_a),
      .ram_read_en(ram_read_en), .ram_write_en(ram_write_en),
      .load_valid(load_valid), .load_ready(load_ready_a),
      .load_addr(load_addr), .load_data(load_data), .load_last(load_last),
      .cpu_hold(cpu_hold_a), .bus_error(bus_error_a)
   );

   memory_responder #(.ADDR_BITS(8), .DATA_BITS(8), .CLEAR_ON_RESET(1'b0)) dut_b (
      .clk(clk), .reset(reset_b),
      .ram_address(ram_address), .ram_data(ram_data_b),
      .ram_read_en(ram_read_en), .ram_write_en(ram_write_en),
      .load_valid(load_valid), .load_ready(load_ready_b),
      .load_addr(load_addr), .load_data(load_data), .load_last(load_last),
      .cpu_hold(cpu_hold_b), .bus_error(bus_error_b)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [7:0] a, input logic [7:0] d, input logic last);
      load_valid = 1'b1;
      load_addr  = a;
      load_data  = d;
      load_last  = last;
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic bus_idle();
      ram_read_en  = 1'b0;
      ram_write_en = 1'b0;
      tb_drv       = 1'b0;
   endtask

   typedef struct {
      logic       re;
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdat;
      logic [7:0] exp_bus;   // value seen on the net mid-cycle (FF = released)
      logic       exp_err;   // bus_error after the edge
   } vec_t;

   vec_t vecs[14];

   typedef struct {
      logic [7:0] addr;
      logic [7:0] exp;
   } rd_t;

   rd_t rds[4];

   initial begin
      logic bad;

      vecs[0]  = '{1'b1, 1'b0, 8'h02, 8'h00, 8'h2A, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 8'h02, 8'h00, 8'hFF, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h10, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 8'h01, 8'h00, 8'h05, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 8'h02, 8'h00, 8'h2A, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 8'h80, 8'h00, 8'h00, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 8'h40, 8'h7F, 8'h7F, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 8'h40, 8'h00, 8'h7F, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 8'hFF, 8'hC3, 8'hC3, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'hC3, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 8'h10, 8'h33, 8'h33, 1'b1};
      vecs[11] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'h33, 1'b1};
      vecs[12] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hFF, 1'b1};
      vecs[13] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h10, 1'b1};

      rds[0] = '{8'h05, 8'h5A};
      rds[1] = '{8'h06, 8'h66};
      rds[2] = '{8'h07, 8'h77};
      rds[3] = '{8'h09, 8'h99};

      reset_a     = 1'b1;
      reset_b     = 1'b1;
      ram_address = 8'h00;
      load_valid  = 1'b0;
      load_last   = 1'b0;
      load_addr   = 8'h00;
      load_data   = 8'h00;
      tb_dat      = 8'h00;
      bus_idle();
      repeat (3) tick();

      // ---- reset state ----
      chk("rst_hold_a",  cpu_hold_a,   1);
      chk("rst_ready_a", load_ready_a, 0);
      chk("rst_err_a",   bus_error_a,  0);
      chk("rst_bus_a",   ram_data_a,   8'hFF);

      // ---- CLEAR sweep: 256 cycles with ready low, then ready high ----
      reset_a = 1'b0;
      bad = 1'b0;
      for (int i = 1; i <= 255; i++) begin
         tick();
         if (load_ready_a !== 1'b0 || cpu_hold_a !== 1'b1) bad = 1'b1;
      end
      chk("clear_ready_low", bad, 0);
      tick();
      chk("clear_done_ready", load_ready_a, 1);
      chk("clear_done_hold",  cpu_hold_a,   1);

      // ---- program load with gaps; stray load_last ignored ----
      beat(8'h00, 8'h10, 1'b0);
      tick();
      beat(8'h01, 8'h05, 1'b0);
      load_last = 1'b1;
      tick();
      tick();
      load_last = 1'b0;
      chk("gap_ready", load_ready_a, 1);
      chk("gap_hold",  cpu_hold_a,   1);
      beat(8'h02, 8'h2A, 1'b1);
      chk("run_hold",  cpu_hold_a,   0);
      chk("run_ready", load_ready_a, 0);

      // ---- RUN bus vectors ----
      for (int i = 0; i < 14; i++) begin
         ram_read_en  = vecs[i].re;
         ram_write_en = vecs[i].we;
         ram_address  = vecs[i].addr;
         tb_drv       = vecs[i].we;
         tb_dat       = vecs[i].wdat;
         @(negedge clk);
         chk($sformatf("vec%0d_bus", i), ram_data_a, vecs[i].exp_bus);
         tick();
         chk($sformatf("vec%0d_err", i), bus_error_a, vecs[i].exp_err);
      end
      bus_idle();

      // ---- load stream ignored in RUN ----
      beat(8'h02, 8'hEE, 1'b1);
      chk("run_load_ready", load_ready_a, 0);
      ram_read_en = 1'b1;
      ram_address = 8'h02;
      @(negedge clk);
      chk("run_load_ignored", ram_data_a, 8'h2A);
      tick();
      bus_idle();

      // ---- second instance: no clear, reset mid-load ----
      reset_a = 1'b1;
      reset_b = 1'b0;
      chk("b_first_ready", load_ready_b, 0);
      tick();
      chk("b_ready", load_ready_b, 1);
      chk("b_hold",  cpu_hold_b,   1);
      beat(8'h05, 8'h5A, 1'b0);
      beat(8'h06, 8'h66, 1'b0);

      ram_write_en = 1'b1;
      ram_address  = 8'h05;
      tb_drv       = 1'b1;
      tb_dat       = 8'h99;
      tick();
      bus_idle();
      chk("b_load_write_err", bus_error_b, 1);

      ram_read_en = 1'b1;
      ram_address = 8'h05;
      @(negedge clk);
      chk("b_load_read_nodrive", ram_data_b, 8'hFF);
      tick();
      bus_idle();

      beat(8'h07, 8'h77, 1'b0);
      load_valid = 1'b1;
      load_addr  = 8'h08;
      load_data  = 8'h88;
      @(negedge clk);
      reset_b = 1'b1;
      #1;
      chk("b_midrst_hold",  cpu_hold_b,   1);
      chk("b_midrst_ready", load_ready_b, 0);
      chk("b_midrst_err",   bus_error_b,  0);
      tick();
      tick();
      load_valid = 1'b0;
      reset_b    = 1'b0;
      tick();
      chk("b_reload_ready", load_ready_b, 1);
      chk("b_reload_hold",  cpu_hold_b,   1);
      beat(8'h09, 8'h99, 1'b1);
      chk("b_run_hold", cpu_hold_b, 0);

      for (int i = 0; i < 4; i++) begin
         ram_read_en = 1'b1;
         ram_address = rds[i].addr;
         @(negedge clk);
         chk($sformatf("b_read_%0h", rds[i].addr), ram_data_b, rds[i].exp);
         tick();
      end
      bus_idle();
      chk("b_final_err", bus_error_b, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
